i8mac_seq: RTL

I8MAC_SEQ -- requirements
Module: i8mac_seq

---
 rtl/i8mac_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/i8mac_seq.sv
// i8mac_seq: sequencer for an 8-bit multiply-accumulate datapath.
// Each job produces n_out results. Each result is one accumulator clear (CLR),
// then depth rdy-qualified accumulate steps (ACC), then a wait for the MAC's
// result strobe (DRAIN). The job ends with a one-clock done pulse (FIN).
// All outputs are registered and are decoded from the next state, so each
// output is valid in the same cycle as the state it belongs to.
module i8mac_seq #(
  parameter int DEPTH_W = 16,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [DEPTH_W-1:0] depth,
  input  logic [CNT_W-1:0]   n_out,
  input  logic               rdy,
  input  logic               acvalid,
  output logic               acl,
  output logic               aen,
  output logic               ivalid,
  output logic [DEPTH_W-1:0] term_idx,
  output logic [CNT_W-1:0]   out_idx,
  output logic               busy,
  output logic               done,
  output logic               err
);

  typedef enum logic [2:0] {IDLE, CLR, ACC, DRAIN, FIN} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [DEPTH_W-1:0] r_depth, w_depth_next;
  logic [CNT_W-1:0]   r_nout, w_nout_next;
  logic [DEPTH_W-1:0] r_term, w_term_next;
  logic [CNT_W-1:0]   r_out, w_out_next;
  logic               r_err, w_err_next;
  logic               r_acl, r_aen, r_ivalid, r_busy, r_done;

  // Next-state and counter logic. Abort has priority over everything except
  // reset. Counters stop on an exact match against the latched limits, so a
  // full-scale depth or n_out never needs the counter to wrap.
  always_comb begin
    w_state_next = r_state;
    w_depth_next = r_depth;
    w_nout_next  = r_nout;
    w_term_next  = r_term;
    w_out_next   = r_out;
    // A result strobe outside DRAIN is a protocol error; the state is unaffected.
    w_err_next   = r_err | (acvalid && (r_state != DRAIN));
    if (abort && (r_state != IDLE)) begin
      w_state_next = IDLE;
      w_err_next   = r_err;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            w_depth_next = depth;
            w_nout_next  = n_out;
            w_term_next  = '0;
            w_out_next   = '0;
            w_err_next   = acvalid;
            // An empty job skips straight to completion without touching the MAC.
            w_state_next = ((depth == '0) || (n_out == '0)) ? FIN : CLR;
          end
        end
        CLR: begin
          if (rdy) w_state_next = ACC;
        end
        ACC: begin
          if (rdy) begin
            if (r_term == r_depth - DEPTH_W'(1)) w_state_next = DRAIN;
            else                                 w_term_next  = r_term + DEPTH_W'(1);
          end
        end
        DRAIN: begin
          if (acvalid) begin
            if (r_out == r_nout - CNT_W'(1)) begin
              w_state_next = FIN;
            end else begin
              w_out_next   = r_out + CNT_W'(1);
              w_term_next  = '0;
              w_state_next = CLR;
            end
          end
        end
        FIN:     w_state_next = IDLE;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_depth  <= '0;
      r_nout   <= '0;
      r_term   <= '0;
      r_out    <= '0;
      r_err    <= 1'b0;
      r_acl    <= 1'b0;
      r_aen    <= 1'b0;
      r_ivalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_depth  <= w_depth_next;
      r_nout   <= w_nout_next;
      r_term   <= w_term_next;
      r_out    <= w_out_next;
      r_err    <= w_err_next;
      r_acl    <= (w_state_next == CLR);
      r_aen    <= (w_state_next == ACC);
      r_ivalid <= (w_state_next == ACC);
      r_busy   <= (w_state_next != IDLE);
      r_done   <= (w_state_next == FIN);
    end
  end

  assign acl      = r_acl;
  assign aen      = r_aen;
  assign ivalid   = r_ivalid;
  assign term_idx = r_term;
  assign out_idx  = r_out;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule
